// File: rtl/random_pool_ctrl_if.sv
// Word pop port between random_pool_ctrl and its consumer (Nios PIO side).
//   o_word       : FIFO head word, registered
//   o_word_valid : FIFO head is valid, registered
//   i_word_ready : consumer pops the head when o_word_valid is high
// master = the pool controller (word source), slave = the consumer.
interface random_pool_ctrl_if;
    logic [31:0] o_word;
    logic        o_word_valid;
    logic        i_word_ready;

    modport master (
        output o_word,
        output o_word_valid,
        input  i_word_ready
    );

    modport slave (
        input  o_word,
        input  o_word_valid,
        output i_word_ready
    );
endinterface

// File: rtl/random_pool_ctrl.sv
// Sequencing controller for the 8-bit random number generator.
// Owns the generator reset/seed, runs the SEED -> WARM -> RUN schedule,
// packs decimated samples little-endian into 32-bit words and buffers them
// in a FIFO drained through a valid/ready pop port.
//
// Ports:
//   i_clk, i_reset     : clock, asynchronous active-high reset
//   i_seed, i_reseed   : seed value and one-cycle restart pulse
//   o_rng_reset_n      : generator reset (low during SEED)
//   o_rng_seed         : latched seed driven to the generator
//   i_rng_data         : generator output byte
//   pop_if             : o_word / o_word_valid / i_word_ready pop port
//   o_level            : words held in the FIFO (0..DEPTH)
//   o_busy             : high in every state except RUN
//   o_overflow         : sticky, a completed word was dropped
//   i_clear_ovf        : clears o_overflow
//
// Optional feature macro: RANDOM_POOL_WHITEN_EN
//   defined   : each packed byte is sample XOR previous raw sample
//   undefined : raw samples are packed
module random_pool_ctrl #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned WARMUP   = 16,
    parameter int unsigned DECIMATE = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [31:0]            i_seed,
    input  logic                   i_reseed,
    output logic                   o_rng_reset_n,
    output logic [31:0]            o_rng_seed,
    input  logic [7:0]             i_rng_data,
    random_pool_ctrl_if.master     pop_if,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_busy,
    output logic                   o_overflow,
    input  logic                   i_clear_ovf
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(WARMUP) + 1;
    localparam int unsigned SW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

    typedef enum logic [1:0] {
        ST_SEED = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          init_q;
    logic          restart_c;
    logic          flush_c;

    logic [31:0]   seed_q;
    logic          rng_rst_n_q;
    logic          busy_q;

    logic [SW-1:0] smp_cnt_q, smp_cnt_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [23:0]   pack_q, pack_d;
    logic          sample_c;
    logic [7:0]    smp_byte_c;
    logic          push_c;
    logic [31:0]   push_word_c;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          valid_q, valid_d;
    logic [31:0]   word_q, word_d;
    logic          ovf_q, ovf_d;
    logic          pop_c;
    logic          full_c;
    logic          wr_en_c;
    logic          ovf_set_c;
    logic          avail_c;

    // The first edge after reset behaves like a reseed so the seed gets latched.
    assign restart_c = i_reseed | init_q;
    assign flush_c   = restart_c | (state_q == ST_SEED);

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_SEED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; cnt counts SEED and WARM cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (restart_c) begin
            state_d = ST_SEED;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_SEED: begin
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_WARM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_WARM: begin
                    if (cnt_q == CW'(WARMUP - 1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_SEED;
            endcase
        end
    end

    assign sample_c = (state_q == ST_RUN) && !restart_c &&
                      (smp_cnt_q == SW'(DECIMATE - 1));

`ifdef RANDOM_POOL_WHITEN_EN
    // Previous raw sample for whitening, cleared whenever the schedule restarts
    logic [7:0] prev_q, prev_d;

    assign smp_byte_c = i_rng_data ^ prev_q;

    always_comb begin
        prev_d = prev_q;
        if (flush_c) begin
            prev_d = '0;
        end else if (sample_c) begin
            prev_d = i_rng_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end
`else
    assign smp_byte_c = i_rng_data;
`endif

    // Decimation counter and little-endian byte packer
    always_comb begin
        smp_cnt_d  = smp_cnt_q;
        byte_cnt_d = byte_cnt_q;
        pack_d     = pack_q;
        if (flush_c) begin
            smp_cnt_d  = '0;
            byte_cnt_d = '0;
            pack_d     = '0;
        end else if (state_q == ST_RUN) begin
            if (sample_c) begin
                smp_cnt_d  = '0;
                byte_cnt_d = byte_cnt_q + 2'd1;
                case (byte_cnt_q)
                    2'd0:    pack_d[7:0]   = smp_byte_c;
                    2'd1:    pack_d[15:8]  = smp_byte_c;
                    2'd2:    pack_d[23:16] = smp_byte_c;
                    default: pack_d        = pack_q;
                endcase
            end else begin
                smp_cnt_d = smp_cnt_q + SW'(1);
            end
        end
    end

    // The fourth sample completes the word and is pushed on the same edge
    assign push_c      = sample_c && (byte_cnt_q == 2'd3);
    assign push_word_c = {smp_byte_c, pack_q};

    // A pop frees a slot on the same edge, so push-and-pop on a full FIFO is accepted
    assign pop_c     = pop_if.i_word_ready && valid_q && !flush_c;
    assign full_c    = (level_q == LW'(DEPTH));
    assign wr_en_c   = push_c && (!full_c || pop_c);
    assign ovf_set_c = push_c && full_c && !pop_c;
    // Head presented next cycle ignores this edge's push, giving the one-cycle valid lag
    assign avail_c   = (level_q - LW'(pop_c)) != '0;

    // FIFO pointers, level, registered head and sticky overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        valid_d  = valid_q;
        word_d   = word_q;
        ovf_d    = ovf_q;
        if (flush_c) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            valid_d  = 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            level_d = level_q + LW'(wr_en_c) - LW'(pop_c);
            valid_d = avail_c;
            if (avail_c) begin
                word_d = mem_q[rd_ptr_d];
            end
        end
        if (ovf_set_c) begin
            ovf_d = 1'b1;
        end else if (i_clear_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // FIFO storage
    always_ff @(posedge i_clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= push_word_c;
        end
    end

    // Datapath and output registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            init_q      <= 1'b1;
            seed_q      <= '0;
            rng_rst_n_q <= 1'b0;
            busy_q      <= 1'b1;
            smp_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            pack_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            valid_q     <= 1'b0;
            word_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            init_q      <= 1'b0;
            if (restart_c) begin
                seed_q <= i_seed;
            end
            rng_rst_n_q <= (state_d != ST_SEED);
            busy_q      <= (state_d != ST_RUN);
            smp_cnt_q   <= smp_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            pack_q      <= pack_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            valid_q     <= valid_d;
            word_q      <= word_d;
            ovf_q       <= ovf_d;
        end
    end

    assign o_rng_reset_n       = rng_rst_n_q;
    assign o_rng_seed          = seed_q;
    assign pop_if.o_word       = word_q;
    assign pop_if.o_word_valid = valid_q;
    assign o_level             = level_q;
    assign o_busy              = busy_q;
    assign o_overflow          = ovf_q;

endmodule
